// File: rtl/rdmx_tx_sched.sv
// rdmx_tx_sched: packet-atomic round-robin scheduler feeding one MAC TX stream.
// One source owns the output from its first beat to TLAST; after TLAST an
// optional inter-packet gap is forced, then a one-cycle arbitration follows.

// Per-lane gate: passes one source onto the shared output only while selected.
module rdmx_tx_sched_lane #(
  parameter int DW = 512
) (
  input  logic            i_sel,
  input  logic [DW-1:0]   i_tdata,
  input  logic [DW/8-1:0] i_tkeep,
  input  logic            i_tlast,
  input  logic            i_tvalid,
  input  logic            i_m_tready,
  output logic [DW-1:0]   o_tdata,
  output logic [DW/8-1:0] o_tkeep,
  output logic            o_tlast,
  output logic            o_tvalid,
  output logic            o_tready
);
  assign o_tdata  = i_tdata & {DW{i_sel}};
  assign o_tkeep  = i_tkeep & {(DW/8){i_sel}};
  assign o_tlast  = i_tlast & i_sel;
  assign o_tvalid = i_tvalid & i_sel;
  assign o_tready = i_m_tready & i_sel;
endmodule

module rdmx_tx_sched #(
  parameter int DW         = 512,
  parameter int NI         = 4,
  parameter int IPG_CYCLES = 0,
  parameter int CW         = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NI*DW-1:0]   S_AXIS_TDATA,
  input  logic [NI*DW/8-1:0] S_AXIS_TKEEP,
  input  logic [NI-1:0]      S_AXIS_TLAST,
  input  logic [NI-1:0]      S_AXIS_TVALID,
  output logic [NI-1:0]      S_AXIS_TREADY,
  output logic [DW-1:0]      M_AXIS_TDATA,
  output logic [DW/8-1:0]    M_AXIS_TKEEP,
  output logic               M_AXIS_TLAST,
  output logic               M_AXIS_TVALID,
  input  logic               M_AXIS_TREADY,
  output logic [NI-1:0]      grant,
  output logic [CW-1:0]      pkt_count
);
  localparam int KW = DW/8;
  localparam int IW = (NI > 1) ? $clog2(NI) : 1;
  localparam logic [7:0] LP_IPG = 8'(IPG_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [NI-1:0]    r_grant;
  logic [IW-1:0]    r_rr_ptr;
  logic [7:0]       r_gap_cnt;
  logic [CW-1:0]    r_pkt_count;

  logic             w_arb_hit;
  logic [IW-1:0]    w_arb_idx;
  logic [IW-1:0]    w_scan;
  logic [NI-1:0]    w_arb_onehot;
  logic [NI-1:0]    w_sel;
  logic             w_xfer_last;

  logic [NI-1:0][DW-1:0] w_lane_tdata;
  logic [NI-1:0][KW-1:0] w_lane_tkeep;
  logic [NI-1:0]         w_lane_tlast;
  logic [NI-1:0]         w_lane_tvalid;

  // Round-robin pick: scan rr_ptr+1 .. rr_ptr+NI (mod NI); the nearest hit wins,
  // so walking from the far end and overwriting leaves the first set bit.
  always_comb begin
    w_arb_hit = 1'b0;
    w_arb_idx = '0;
    w_scan    = '0;
    for (int k = NI; k >= 1; k--) begin
      w_scan = IW'((int'(r_rr_ptr) + k) % NI);
      if (S_AXIS_TVALID[w_scan]) begin
        w_arb_hit = 1'b1;
        w_arb_idx = w_scan;
      end
    end
  end

  assign w_arb_onehot = NI'(1) << w_arb_idx;

  // Only the owner lane is opened, and only while a packet is being passed.
  assign w_sel = (r_state == ST_PASS) ? r_grant : '0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_lane
    rdmx_tx_sched_lane #(.DW(DW)) u_lane (
      .i_sel      (w_sel[gi]),
      .i_tdata    (S_AXIS_TDATA[gi*DW +: DW]),
      .i_tkeep    (S_AXIS_TKEEP[gi*KW +: KW]),
      .i_tlast    (S_AXIS_TLAST[gi]),
      .i_tvalid   (S_AXIS_TVALID[gi]),
      .i_m_tready (M_AXIS_TREADY),
      .o_tdata    (w_lane_tdata[gi]),
      .o_tkeep    (w_lane_tkeep[gi]),
      .o_tlast    (w_lane_tlast[gi]),
      .o_tvalid   (w_lane_tvalid[gi]),
      .o_tready   (S_AXIS_TREADY[gi])
    );
  end

  // OR-combine the gated lanes; at most one is open, so this is the output mux.
  always_comb begin
    M_AXIS_TDATA  = '0;
    M_AXIS_TKEEP  = '0;
    M_AXIS_TLAST  = 1'b0;
    M_AXIS_TVALID = 1'b0;
    for (int i = 0; i < NI; i++) begin
      M_AXIS_TDATA  = M_AXIS_TDATA | w_lane_tdata[i];
      M_AXIS_TKEEP  = M_AXIS_TKEEP | w_lane_tkeep[i];
      M_AXIS_TLAST  = M_AXIS_TLAST | w_lane_tlast[i];
      M_AXIS_TVALID = M_AXIS_TVALID | w_lane_tvalid[i];
    end
  end

  assign w_xfer_last = M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST;

  // Next-state logic: IDLE arbitrates, PASS waits for the TLAST handshake,
  // GAP counts down the forced idle time.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_arb_hit) w_state_nxt = ST_PASS;
      ST_PASS: if (w_xfer_last) w_state_nxt = (IPG_CYCLES == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:  if (r_gap_cnt <= 8'd1) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Grant ownership and round-robin pointer; pointer reset to NI-1 makes 0 first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant  <= '0;
      r_rr_ptr <= IW'(NI-1);
    end else if (r_state == ST_IDLE && w_arb_hit) begin
      r_grant  <= w_arb_onehot;
      r_rr_ptr <= w_arb_idx;
    end else if (r_state == ST_PASS && w_xfer_last) begin
      r_grant  <= '0;
    end
  end

  // Inter-packet gap counter: loaded on TLAST, counts down while in GAP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   r_gap_cnt <= '0;
    else if (r_state == ST_PASS && w_xfer_last)  r_gap_cnt <= LP_IPG;
    else if (r_state == ST_GAP)                  r_gap_cnt <= r_gap_cnt - 8'd1;
  end

  // Completed-packet counter, free-running modulo 2^CW.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   r_pkt_count <= '0;
    else if (r_state == ST_PASS && w_xfer_last)  r_pkt_count <= r_pkt_count + CW'(1);
  end

  assign grant     = r_grant;
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_rdmx_tx_sched.sv
// Scoreboard bench for rdmx_tx_sched: two instances (gap 0 and gap 3) share
// stimulus; 'sel' chooses which one the sources and monitor talk to.
module tb_rdmx_tx_sched;
  localparam int DW = 64;
  localparam int NI = 4;
  localparam int KW = DW/8;
  localparam int CW = 16;

  typedef struct { logic [DW-1:0] d; logic [KW-1:0] k; logic l; int gap; } beat_t;
  typedef struct { logic [DW-1:0] d; logic [KW-1:0] k; logic l; logic [NI-1:0] g; } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              sel;
  logic              tog;
  logic [NI*DW-1:0]  s_tdata;
  logic [NI*KW-1:0]  s_tkeep;
  logic [NI-1:0]     s_tlast, s_tvalid;
  logic              m_tready;

  logic [NI-1:0] s_tready0, s_tready3, grant0, grant3;
  logic [DW-1:0] m_tdata0, m_tdata3;
  logic [KW-1:0] m_tkeep0, m_tkeep3;
  logic          m_tlast0, m_tlast3, m_tvalid0, m_tvalid3;
  logic [CW-1:0] cnt0, cnt3;

  rdmx_tx_sched #(.DW(DW), .NI(NI), .IPG_CYCLES(0), .CW(CW)) dut0 (
    .clk(clk), .reset(reset),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TKEEP(s_tkeep), .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready0),
    .M_AXIS_TDATA(m_tdata0), .M_AXIS_TKEEP(m_tkeep0), .M_AXIS_TLAST(m_tlast0),
    .M_AXIS_TVALID(m_tvalid0), .M_AXIS_TREADY(m_tready),
    .grant(grant0), .pkt_count(cnt0));

  rdmx_tx_sched #(.DW(DW), .NI(NI), .IPG_CYCLES(3), .CW(CW)) dut3 (
    .clk(clk), .reset(reset),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TKEEP(s_tkeep), .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready3),
    .M_AXIS_TDATA(m_tdata3), .M_AXIS_TKEEP(m_tkeep3), .M_AXIS_TLAST(m_tlast3),
    .M_AXIS_TVALID(m_tvalid3), .M_AXIS_TREADY(m_tready),
    .grant(grant3), .pkt_count(cnt3));

  wire [NI-1:0] s_tready = sel ? s_tready3 : s_tready0;
  wire [NI-1:0] grant    = sel ? grant3    : grant0;
  wire [DW-1:0] m_tdata  = sel ? m_tdata3  : m_tdata0;
  wire [KW-1:0] m_tkeep  = sel ? m_tkeep3  : m_tkeep0;
  wire          m_tlast  = sel ? m_tlast3  : m_tlast0;
  wire          m_tvalid = sel ? m_tvalid3 : m_tvalid0;
  wire [CW-1:0] cnt      = sel ? cnt3      : cnt0;

  beat_t sq[NI][$];
  exp_t  eq[$];
  int    xc[$];
  logic  xl[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  function automatic beat_t mk(int src, int id, int b, int n, int gap);
    beat_t t;
    t.d   = {16'hA5C3, 8'(src), 8'(id), 8'(b), 8'(n), 16'(id*256 + b*17 + src)};
    t.k   = (b == n-1) ? 8'(8'hFF >> (id % 4)) : 8'hFF;
    t.l   = (b == n-1);
    t.gap = gap;
    return t;
  endfunction

  task automatic src_pkt(input int src, input int id, input int n,
                         input int stall_beat = -1, input int stall = 0);
    for (int b = 0; b < n; b++) sq[src].push_back(mk(src, id, b, n, (b == stall_beat) ? stall : 0));
  endtask

  task automatic exp_beat(input int src, input int id, input int b, input int n);
    beat_t t;
    exp_t  e;
    t = mk(src, id, b, n, 0);
    e.d = t.d; e.k = t.k; e.l = t.l; e.g = NI'(1) << src;
    eq.push_back(e);
  endtask

  task automatic exp_pkt(input int src, input int id, input int n);
    for (int b = 0; b < n; b++) exp_beat(src, id, b, n);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (eq.size() > 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (eq.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d beats still pending after %0d cycles", eq.size(), budget);
      eq.delete();
    end
    @(negedge clk); #1;
  endtask

  task automatic wait_xfers(input int want, input int budget);
    int n = 0;
    while (xc.size() < want && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (xc.size() < want) begin
      errors++;
      $display("FAIL wait_xfers: got %0d transfers, expected %0d", xc.size(), want);
    end
  endtask

  task automatic do_reset(input logic s);
    reset = 1'b1;
    sel   = s;
    for (int i = 0; i < NI; i++) sq[i].delete();
    eq.delete();
    repeat (2) @(negedge clk);
    xc.delete();
    xl.delete();
    reset = 1'b0;
    @(negedge clk); #1;
  endtask

  // Source driver: samples handshakes at negedge, advances queues after posedge.
  initial begin
    logic [NI-1:0] fire;
    int            hold[NI];
    bit            loaded[NI];
    fire = '0;
    s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tvalid = '0; m_tready = 1'b1;
    for (int i = 0; i < NI; i++) begin hold[i] = 0; loaded[i] = 1'b0; end
    forever begin
      @(negedge clk);
      fire = s_tvalid & s_tready;
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        if (fire[i] && sq[i].size() > 0) begin
          void'(sq[i].pop_front());
          loaded[i] = 1'b0;
        end
        if (sq[i].size() == 0) loaded[i] = 1'b0;
        if (sq[i].size() > 0 && !loaded[i]) begin
          hold[i]   = sq[i][0].gap;
          loaded[i] = 1'b1;
        end
        if (hold[i] > 0) begin
          s_tvalid[i] = 1'b0;
          hold[i]--;
        end else begin
          s_tvalid[i] = (sq[i].size() > 0);
        end
        if (sq[i].size() > 0) begin
          s_tdata[i*DW +: DW] = sq[i][0].d;
          s_tkeep[i*KW +: KW] = sq[i][0].k;
          s_tlast[i]          = sq[i][0].l;
        end else begin
          s_tdata[i*DW +: DW] = '0;
          s_tkeep[i*KW +: KW] = '0;
          s_tlast[i]          = 1'b0;
        end
      end
      m_tready = tog ? ~m_tready : 1'b1;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every M-side handshake is popped against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && m_tvalid && m_tready) begin
        checks++;
        if (eq.size() == 0) begin
          errors++;
          $display("FAIL beat: unexpected beat d=%h l=%b g=%b", m_tdata, m_tlast, grant);
        end else begin
          e = eq.pop_front();
          if (m_tdata !== e.d || m_tkeep !== e.k || m_tlast !== e.l || grant !== e.g) begin
            errors++;
            $display("FAIL beat: got d=%h k=%h l=%b g=%b, expected d=%h k=%h l=%b g=%b",
                     m_tdata, m_tkeep, m_tlast, grant, e.d, e.k, e.l, e.g);
          end
        end
        xc.push_back(cyc);
        xl.push_back(m_tlast);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Directed scenarios.
  initial begin
    reset = 1'b1; sel = 1'b0; tog = 1'b0;
    @(negedge clk); #1;
    chk("rst_grant",   {grant0, grant3}, 8'h00);
    chk("rst_mvalid",  {m_tvalid0, m_tvalid3}, 2'b00);
    chk("rst_sready",  {s_tready0, s_tready3}, 8'h00);
    chk("rst_cnt",     {cnt0, cnt3}, 32'h0);
    chk("rst_mdata",   m_tdata0, 64'h0);

    // Single source 2, 3-beat packet, one arbitration cycle.
    do_reset(1'b0);
    src_pkt(2, 1, 3);
    exp_pkt(2, 1, 3);
    @(negedge clk); #1;
    chk("s1_grant_idle", grant, 4'b0000);
    @(negedge clk); #1;
    chk("s1_grant_pass", grant, 4'b0100);
    drain(20);
    chk("s1_nxfer", xc.size(), 3);
    if (xc.size() == 3) chk("s1_consec", xc[2] - xc[0], 2);
    chk("s1_grant_end", grant, 4'b0000);
    chk("s1_cnt", cnt, 1);

    // All four sources requesting: order 0,1,2,3,0 with one idle cycle each.
    do_reset(1'b0);
    src_pkt(0, 1, 2); src_pkt(0, 5, 2);
    src_pkt(1, 2, 2); src_pkt(2, 3, 2); src_pkt(3, 4, 2);
    exp_pkt(0, 1, 2); exp_pkt(1, 2, 2); exp_pkt(2, 3, 2); exp_pkt(3, 4, 2); exp_pkt(0, 5, 2);
    drain(60);
    chk("s2_nxfer", xc.size(), 10);
    if (xc.size() == 10) begin
      for (int p = 0; p < 5; p++) chk("s2_inpkt", xc[2*p+1] - xc[2*p], 1);
      for (int p = 0; p < 4; p++) chk("s2_gap", xc[2*p+2] - xc[2*p+1], 2);
    end
    chk("s2_cnt", cnt, 5);

    // IPG_CYCLES=3: four dead cycles between back-to-back packets.
    do_reset(1'b1);
    src_pkt(1, 1, 2); src_pkt(1, 2, 2);
    exp_pkt(1, 1, 2); exp_pkt(1, 2, 2);
    drain(40);
    chk("s3_nxfer", xc.size(), 4);
    if (xc.size() == 4) chk("s3_gap", xc[2] - xc[1], 5);
    chk("s3_cnt", cnt, 2);

    // Source 0 stalls 5 cycles mid-packet; source 3 must wait for TLAST.
    do_reset(1'b0);
    src_pkt(0, 1, 4, 2, 5);
    src_pkt(3, 2, 2);
    exp_pkt(0, 1, 4); exp_pkt(3, 2, 2);
    wait_xfers(2, 20);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk("s4_hold_grant", grant, 4'b0001);
      chk("s4_hold_rdy3", s_tready[3], 1'b0);
      chk("s4_hold_mvalid", m_tvalid, 1'b0);
    end
    drain(40);
    chk("s4_cnt", cnt, 2);

    // M-side ready toggling: every beat delivered once, TLAST only on beat 4.
    do_reset(1'b0);
    tog = 1'b1;
    src_pkt(2, 3, 4);
    exp_pkt(2, 3, 4);
    drain(40);
    tog = 1'b0;
    chk("s5_nxfer", xc.size(), 4);
    if (xc.size() == 4) begin
      chk("s5_last", {xl[0], xl[1], xl[2], xl[3]}, 4'b0001);
      chk("s5_span", xc[3] - xc[0], 6);
    end

    // Reset during beat 2 of a source-1 packet.
    do_reset(1'b0);
    src_pkt(1, 4, 4);
    exp_beat(1, 4, 0, 4);
    wait_xfers(1, 20);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("s6_rst_out", {m_tvalid, m_tlast, m_tkeep, grant, s_tready}, 64'h0);
    chk("s6_rst_data", m_tdata, 64'h0);
    sq[1].delete();
    src_pkt(0, 5, 1);
    src_pkt(1, 6, 2);
    exp_pkt(0, 5, 1); exp_pkt(1, 6, 2);
    repeat (2) @(negedge clk);
    #1;
    chk("s6_rst_out2", {m_tvalid, m_tlast, m_tkeep, grant, s_tready}, 64'h0);
    chk("s6_rst_data2", m_tdata, 64'h0);
    reset = 1'b0;
    chk("s6_cnt0", cnt, 0);
    drain(30);
    chk("s6_cnt", cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
